// File: rtl/c880_pkg.sv
// Shared types and constants for the c880 ALU scheduler slice.
package c880_pkg;

    localparam int unsigned C880_NUM_PI = 60;
    localparam int unsigned C880_NUM_PO = 26;

    typedef logic [C880_NUM_PI-1:0] c880_in_t;
    typedef logic [C880_NUM_PO-1:0] c880_out_t;

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} sched_state_e;

endpackage

// File: rtl/c880_alu_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit at or above ptr, with wrap.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int unsigned   cand;
    logic [IW-1:0] cidx;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        cidx = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = (32'(ptr) + off) % N;
            cidx = IW'(cand);
            if (!any && req[cidx]) begin
                gnt[cidx] = 1'b1;
                idx       = cidx;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/c880_alu_scheduler.sv
// Round-robin sequencer sharing one c880 ALU; holds inputs SETTLE_CYCLES before capture.
// Optional even parity on the captured result: define C880_SCHED_PARITY_EN.
module c880_alu_scheduler
    import c880_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0][C880_NUM_PI-1:0]   req_operand,
    output logic [C880_NUM_PI-1:0]                alu_in,
    input  logic [C880_NUM_PO-1:0]                alu_out,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]            rsp_id,
    output logic [C880_NUM_PO-1:0]                rsp_result,
    output logic                                  rsp_parity,
    output logic                                  busy
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);

    sched_state_e     state;
    logic [IdW-1:0]   ptr;
    logic [IdW-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_gnt;
    logic             win_any;
    logic [CntW-1:0]  cnt;
    logic             capture;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IdW)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (win_gnt),
        .idx (win_idx),
        .any (win_any)
    );

    assign req_ready = (state == IDLE) ? win_gnt : '0;
    assign busy      = (state != IDLE);
    assign capture   = (state == SETTLE) && (cnt == CntW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            alu_in     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            ptr        <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        alu_in <= req_operand[win_idx];
                        rsp_id <= win_idx;
                        cnt    <= CntW'(SETTLE_CYCLES);
                        // Explicit wrap so non-power-of-two NUM_REQ never points past the last requester.
                        ptr    <= (win_idx == IdW'(NUM_REQ - 1)) ? '0 : win_idx + IdW'(1);
                        state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt <= cnt - CntW'(1);
                    if (capture) begin
                        rsp_result <= alu_out;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef C880_SCHED_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_parity <= 1'b0;
        end else if (capture) begin
            rsp_parity <= ^alu_out;
        end
    end
`else
    assign rsp_parity = 1'b0;
`endif

endmodule

// File: tb/tb_c880_alu_scheduler.sv
// Directed bench for c880_alu_scheduler with a small stand-in combinational ALU.
module tb_c880_alu_scheduler;
    import c880_pkg::*;

`ifdef C880_SCHED_PARITY_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [3:0]             req_valid;
    logic [3:0]             req_ready;
    logic [3:0][59:0]       req_operand;
    logic [59:0]            alu_in;
    logic [25:0]            alu_out;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_id;
    logic [25:0]            rsp_result;
    logic                   rsp_parity;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    c880_alu_scheduler #(
        .NUM_REQ       (4),
        .SETTLE_CYCLES (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_operand (req_operand),
        .alu_in      (alu_in),
        .alu_out     (alu_out),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_parity  (rsp_parity),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: out = in[25:0] ^ in[51:26], with out[3] also toggled by in[17] & in[18].
    always_comb begin
        alu_out    = alu_in[25:0] ^ alu_in[51:26];
        alu_out[3] = alu_out[3] ^ (alu_in[17] & alu_in[18]);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the accept cycle with rsp_ready=1; returns in the following IDLE cycle.
    task automatic run_op(input int id, input logic [59:0] op, input logic [25:0] res);
        logic [3:0] g;
        g = 4'b0001 << id;
        chk("grant", req_ready, g);
        step();
        chk("alu_in", alu_in, op);
        chk("settle_busy", busy, 1);
        chk("settle_ready", req_ready, 0);
        step();
        step();
        chk("pre_rsp", rsp_valid, 0);
        step();
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, id);
        chk("rsp_result", rsp_result, res);
        chk("rsp_parity", rsp_parity, ParEn ? ^res : 1'b0);
        step();
        chk("rsp_drop", rsp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        req_valid   = '0;
        req_operand = '0;
        rsp_ready   = 1'b1;
        step();
        step();
        chk("rst_alu_in", alu_in, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_parity", rsp_parity, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);

        // 1: inputs 85/86 (bits 17,18) -> out bits 17,18 and 3.
        rst            = 1'b0;
        req_operand[0] = (60'h1 << 17) | (60'h1 << 18);
        req_valid      = 4'b0001;
        #1;
        run_op(0, (60'h1 << 17) | (60'h1 << 18), 26'h006_0008);
        req_valid = '0;
        step();
        chk("idle_no_req", busy, 0);

        // 2: all valid from ptr=0 -> 0,1,2,3,0 spaced 5 cycles.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) req_operand[k] = 60'(k + 1);
        req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) run_op(g % 4, 60'(g % 4 + 1), 26'(g % 4 + 1));
        req_valid = '0;

        // 3: grant 1 -> ptr=2; then 1 and 3 valid -> 3 first, then 1.
        req_operand[1] = 60'h0AB;
        req_operand[3] = (60'h1 << 26) | 60'h2;
        req_valid      = 4'b0010;
        #1;
        run_op(1, 60'h0AB, 26'h0AB);
        req_valid = 4'b1010;
        #1;
        run_op(3, (60'h1 << 26) | 60'h2, 26'h3);
        run_op(1, 60'h0AB, 26'h0AB);
        req_valid = '0;

        // 4: back-pressure; ptr=2 so requester 0 wins, ptr becomes 1.
        rsp_ready      = 1'b0;
        req_operand[0] = 60'h123;
        req_valid      = 4'b0001;
        #1;
        chk("bp_grant", req_ready, 4'b0001);
        step();
        req_valid      = 4'b1111;
        req_operand[0] = 60'hFFF;
        step();
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, 0);
            chk("bp_result", rsp_result, 26'h123);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_alu_in", alu_in, 60'h123);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_release_grant", req_ready, 4'b0010);
        step();
        chk("bp_accept_busy", busy, 1);
        chk("bp_accept_alu_in", alu_in, 60'h0AB);
        req_valid = '0;
        step();
        step();
        step();
        chk("bp_next_id", rsp_id, 1);
        step();

        // 5: reset during the second SETTLE cycle.
        req_operand[0] = 60'h55;
        req_valid      = 4'b0001;
        #1;
        chk("mid_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        step();
        rst = 1'b1;
        step();
        chk("mid_alu_in", alu_in, 0);
        chk("mid_busy", busy, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_rsp_id", rsp_id, 0);
        chk("mid_rsp_result", rsp_result, 0);
        chk("mid_rsp_parity", rsp_parity, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mid_no_rsp", rsp_valid, 0);
        end

        // 6: parity on all-zero and on 3-bit results.
        req_operand[0] = '0;
        req_valid      = 4'b0001;
        #1;
        run_op(0, 60'h0, 26'h0);
        req_operand[1] = 60'h7;
        req_valid      = 4'b0010;
        #1;
        run_op(1, 60'h7, 26'h7);
        req_valid = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
